// File: rtl/sum_accum_stage.sv
// Burst accumulator behind a small input FIFO: sums BURST_LEN 17-bit samples and
// presents the total with a valid/ready handshake. Define SUM_ACCUM_SAT_EN to saturate instead of wrap.
module sum_accum_stage #(
    parameter int WIDTH      = 32,
    parameter int ACC_W      = 20,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       acc_count,
    output logic             overflow,
    output logic [0:0]       state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends only on FIFO occupancy; out_valid is high exactly in DONE.

    logic [16:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill_q, fill_d;
    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_add;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             push, pop, add_ovf;
    logic [16:0]      sample, head;
    logic [ACC_W:0]   sum_ext;
    logic             unused_sum_hi;

    assign unused_sum_hi = ^sum_in[WIDTH-1:16];
    assign sample        = {cout_in, sum_in[15:0]};
    assign head          = mem_q[rd_ptr_q];

    assign in_ready  = (fill_q != (PTR_W+1)'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    // No pop while clearing, so the entry at the head survives an abort.
    assign pop       = (state_q == ST_ACCUM) && (fill_q != '0) && !acc_clear;

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W-16){1'b0}}, head};
    assign add_ovf = sum_ext[ACC_W];

`ifdef SUM_ACCUM_SAT_EN
    assign acc_add = add_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_add = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
            2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (acc_clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_DONE) begin
            if (out_ready) begin
                state_d = ST_ACCUM;
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
        end else if (pop) begin
            acc_d   = acc_add;
            count_d = count_q + 8'd1;
            ovf_d   = ovf_q | add_ovf;
            if (count_q + 8'd1 == 8'(BURST_LEN)) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fill_q  <= fill_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign acc_out   = acc_q;
    assign acc_count = count_q;
    assign overflow  = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sum_accum_stage.sv
// Directed plus randomized bench for sum_accum_stage: instance 0 uses BURST_LEN=4,
// instance 1 the defaults; burst totals come from a queue-based arithmetic model.
module tb_sum_accum_stage;

    localparam int ACC_W = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv [2];
    logic [31:0] si [2];
    logic        ci [2];
    logic        ac [2];
    logic        ordy [2];
    logic        ir [2];
    logic        ov [2];
    logic [19:0] ao [2];
    logic [7:0]  cnt [2];
    logic        of [2];
    logic [0:0]  st [2];

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] exp_q0[$];
    logic [16:0] exp_q1[$];

    always #5 clk = ~clk;

    sum_accum_stage #(.WIDTH(32), .ACC_W(ACC_W), .BURST_LEN(4), .FIFO_DEPTH(4)) u_b4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .sum_in(si[0]),
        .cout_in(ci[0]), .acc_clear(ac[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .acc_out(ao[0]), .acc_count(cnt[0]), .overflow(of[0]), .state_o(st[0])
    );

    sum_accum_stage u_b16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .sum_in(si[1]),
        .cout_in(ci[1]), .acc_clear(ac[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .acc_out(ao[1]), .acc_count(cnt[1]), .overflow(of[1]), .state_o(st[1])
    );

    function automatic int bl(input int k);
        return (k == 0) ? 4 : 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic q_push(input int k, input logic [16:0] s);
        if (k == 0) exp_q0.push_back(s);
        else        exp_q1.push_back(s);
    endtask

    task automatic q_pop(input int k, output logic [16:0] s);
        s = '0;
        if (k == 0) begin
            if (exp_q0.size() > 0) s = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() > 0) s = exp_q1.pop_front();
        end
    endtask

    // One cycle with in_valid high; the sample joins the model only if accepted.
    task automatic try_push(input int k, input logic [16:0] s, output bit taken);
        iv[k] = 1'b1;
        si[k] = {16'($urandom_range(0, 16'hFFFF)), s[15:0]};
        ci[k] = s[16];
        taken = ir[k];
        if (taken) q_push(k, s);
        step();
        iv[k] = 1'b0;
    endtask

    task automatic push(input int k, input logic [16:0] s);
        bit taken = 1'b0;
        for (int i = 0; i < 50 && !taken; i++) try_push(k, s, taken);
        chk("push_accepted", {31'd0, taken}, 32'd1);
    endtask

    // Expected burst total: plain arithmetic over the next BURST_LEN accepted samples.
    task automatic model_burst(input int k, output logic [19:0] tot, output logic ovf);
        longint acc = 0;
        logic [16:0] s;
        ovf = 1'b0;
        for (int i = 0; i < bl(k); i++) begin
            q_pop(k, s);
            acc = acc + longint'(s);
            if (acc > (longint'(1) << ACC_W) - 1) begin
                ovf = 1'b1;
`ifdef SUM_ACCUM_SAT_EN
                acc = (longint'(1) << ACC_W) - 1;
`else
                acc = acc % (longint'(1) << ACC_W);
`endif
            end
        end
        tot = 20'(acc);
    endtask

    task automatic check_done(input int k, output logic [19:0] tot);
        logic ovf;
        for (int i = 0; i < 400 && ov[k] !== 1'b1; i++) step();
        chk("out_valid_seen", {31'd0, ov[k]}, 32'd1);
        model_burst(k, tot, ovf);
        chk("acc_out", {12'd0, ao[k]}, {12'd0, tot});
        chk("acc_count", {24'd0, cnt[k]}, bl(k));
        chk("overflow", {31'd0, of[k]}, {31'd0, ovf});
    endtask

    task automatic handshake(input int k);
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        chk("hs_out_valid", {31'd0, ov[k]}, 32'd0);
        chk("hs_count", {24'd0, cnt[k]}, 32'd0);
        chk("hs_overflow", {31'd0, of[k]}, 32'd0);
    endtask

    task automatic rand_burst(input int k, input bit big);
        logic [19:0] tot;
        for (int i = 0; i < bl(k); i++) begin
            repeat ($urandom_range(0, 2)) step();
            push(k, big ? 17'($urandom_range(0, 17'h1FFFF)) : 17'($urandom_range(0, 4095)));
        end
        check_done(k, tot);
        repeat ($urandom_range(0, 3)) step();
        chk("done_hold", {12'd0, ao[k]}, {12'd0, tot});
        handshake(k);
    endtask

    task automatic check_reset_outputs(input int k);
        chk("rst_in_ready", {31'd0, ir[k]}, 32'd1);
        chk("rst_out_valid", {31'd0, ov[k]}, 32'd0);
        chk("rst_acc_out", {12'd0, ao[k]}, 32'd0);
        chk("rst_acc_count", {24'd0, cnt[k]}, 32'd0);
        chk("rst_overflow", {31'd0, of[k]}, 32'd0);
    endtask

    initial begin
        logic [19:0] tot;
        logic [16:0] junk;
        int          n_taken;
        bit          taken;

        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; si[k] = '0; ci[k] = 1'b0; ac[k] = 1'b0; ordy[k] = 1'b0;
        end
        repeat (3) step();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b1;
        step();

        // Scenario 1: 1,2,3,4 back-to-back into BURST_LEN=4, out_ready held high.
        ordy[0] = 1'b1;
        for (int i = 1; i <= 4; i++) try_push(0, 17'(i), taken);
        chk("s1_not_yet", {31'd0, ov[0]}, 32'd0);
        step();
        chk("s1_valid", {31'd0, ov[0]}, 32'd1);
        chk("s1_total", {12'd0, ao[0]}, 32'd10);
        chk("s1_count", {24'd0, cnt[0]}, 32'd4);
        model_burst(0, tot, junk[0]);
        step();
        chk("s1_one_cycle", {31'd0, ov[0]}, 32'd0);
        chk("s1_cleared", {24'd0, cnt[0]}, 32'd0);
        ordy[0] = 1'b0;

        // Scenario 2: 16 full-scale samples overflow the 20-bit accumulator.
        for (int i = 0; i < 16; i++) push(1, 17'h1FFFF);
        check_done(1, tot);
`ifdef SUM_ACCUM_SAT_EN
        chk("s2_total", {12'd0, ao[1]}, 32'hFFFFF);
`else
        chk("s2_total", {12'd0, ao[1]}, 32'hFFFF0);
`endif
        chk("s2_overflow", {31'd0, of[1]}, 32'd1);
        handshake(1);

        // Scenario 3: stalled in DONE, only FIFO_DEPTH of 6 pushes fit.
        for (int i = 0; i < 16; i++) push(1, 17'($urandom_range(0, 8191)));
        check_done(1, tot);
        n_taken = 0;
        for (int i = 0; i < 6; i++) begin
            try_push(1, 17'($urandom_range(0, 17'h1FFFF)), taken);
            n_taken += int'(taken);
        end
        chk("s3_accepted", n_taken, 32'd4);
        chk("s3_in_ready", {31'd0, ir[1]}, 32'd0);
        chk("s3_hold_total", {12'd0, ao[1]}, {12'd0, tot});
        chk("s3_hold_count", {24'd0, cnt[1]}, 32'd16);
        handshake(1);
        for (int i = 0; i < 12; i++) push(1, 17'($urandom_range(0, 17'h1FFFF)));
        check_done(1, tot);
        handshake(1);

        // Scenario 4: abort after 7 samples, then a clean burst.
        for (int i = 0; i < 7; i++) push(1, 17'($urandom_range(0, 17'h1FFFF)));
        repeat (3) step();
        chk("s4_partial", {24'd0, cnt[1]}, 32'd7);
        ac[1] = 1'b1;
        step();
        ac[1] = 1'b0;
        chk("s4_count", {24'd0, cnt[1]}, 32'd0);
        chk("s4_acc", {12'd0, ao[1]}, 32'd0);
        chk("s4_overflow", {31'd0, of[1]}, 32'd0);
        chk("s4_no_valid", {31'd0, ov[1]}, 32'd0);
        for (int i = 0; i < 7; i++) q_pop(1, junk);
        for (int i = 0; i < 16; i++) push(1, 17'($urandom_range(0, 17'h1FFFF)));
        check_done(1, tot);
        handshake(1);

        // Scenario 5: reset while in DONE with 3 samples buffered.
        for (int i = 0; i < 16; i++) push(1, 17'($urandom_range(0, 17'h1FFFF)));
        check_done(1, tot);
        for (int i = 0; i < 3; i++) push(1, 17'($urandom_range(0, 17'h1FFFF)));
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_reset_outputs(1);
        check_reset_outputs(0);
        exp_q0.delete();
        exp_q1.delete();
        rand_burst(1, 1'b1);

        // Scenario 6: clear wins over a same-cycle output handshake.
        for (int i = 0; i < 16; i++) push(1, 17'($urandom_range(0, 17'h1FFFF)));
        check_done(1, tot);
        ordy[1] = 1'b1;
        ac[1] = 1'b1;
        step();
        ordy[1] = 1'b0;
        ac[1] = 1'b0;
        chk("s6_out_valid", {31'd0, ov[1]}, 32'd0);
        chk("s6_count", {24'd0, cnt[1]}, 32'd0);
        chk("s6_acc", {12'd0, ao[1]}, 32'd0);
        chk("s6_state_accum", {31'd0, st[1]}, 32'd0);
        rand_burst(1, 1'b0);

        // Randomized bursts on both instances.
        for (int r = 0; r < 6; r++) begin
            rand_burst(0, r[0]);
            rand_burst(1, ~r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sum_accum_stage.md
SUM_ACCUM_STAGE -- requirements
Module: sum_accum_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of the sum_in result bus.
REQ-002 The block SHALL have parameter ACC_W, default 20: accumulator and acc_out width.
REQ-003 The block SHALL have parameter BURST_LEN, default 16: samples per accumulation, legal range 2..255.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: input buffer entries, power of two.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream adder result valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: buffer can accept a sample.
REQ-009 The block SHALL have port sum_in, input, WIDTH bits: adder sum; only bits [15:0] are used.
REQ-010 The block SHALL have port cout_in, input, 1 bit: adder carry-out.
REQ-011 The block SHALL have port acc_clear, input, 1 bit: synchronous abort of the current burst.
REQ-012 The block SHALL have port out_valid, output, 1 bit: burst total available.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the total.
REQ-014 The block SHALL have port acc_out, output, ACC_W bits: burst total.
REQ-015 The block SHALL have port acc_count, output, 8 bits: samples accumulated in the current burst.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky accumulator overflow flag.

Function
REQ-017 The sample SHALL be the 17-bit unsigned value {cout_in, sum_in[15:0]}, zero-extended to ACC_W.
REQ-018 A push SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high exactly when the FIFO holds fewer than FIFO_DEPTH entries, independent of in_valid.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-020 The FSM SHALL have two states: ACCUM and DONE.
REQ-021 In ACCUM with the FIFO non-empty, the block SHALL pop one entry per cycle, add it to the accumulator, and increment acc_count.
REQ-022 The pop that makes acc_count equal BURST_LEN SHALL move the FSM to DONE on the same edge; out_valid SHALL then be high.
REQ-023 In DONE the block SHALL perform no pops, hold acc_out and acc_count stable, and keep accepting pushes until the FIFO is full.
REQ-024 When out_valid and out_ready are both high, the FSM SHALL return to ACCUM on that edge with accumulator 0 and acc_count 0.
REQ-025 Latency SHALL be 2 edges: from the push of the final sample into an empty FIFO to out_valid high.
REQ-026 When acc_clear is high, the accumulator, acc_count and overflow SHALL be zeroed, the FSM SHALL return to ACCUM, and out_valid SHALL drop; FIFO contents SHALL be kept and no pop SHALL occur that cycle.
REQ-027 acc_clear SHALL take priority over an out_valid/out_ready handshake in the same cycle, and that total SHALL be discarded.
REQ-028 overflow SHALL be set by any add whose true sum exceeds 2^ACC_W-1, and SHALL clear only on reset, acc_clear, or the output handshake.

Reset
REQ-029 While rst is 0 at a clock edge, the block SHALL set: FSM ACCUM, FIFO empty, in_ready 1, out_valid 0, acc_out 0, acc_count 0, overflow 0.
REQ-030 Reset asserted mid-burst or in DONE SHALL discard all buffered and accumulated data with no partial output.

Configuration
REQ-031 With macro SUM_ACCUM_SAT_EN defined, an overflowing add SHALL clamp the accumulator to 2^ACC_W-1, and further adds in that burst SHALL keep it clamped.
REQ-032 Without SUM_ACCUM_SAT_EN, the accumulator SHALL wrap modulo 2^ACC_W; overflow SHALL be set under both configurations.

Verification
REQ-033 Scenario 1: BURST_LEN=4, samples 1,2,3,4 back-to-back, out_ready=1 -> acc_out=10 and out_valid high for one cycle, 2 edges after the last push.
REQ-034 Scenario 2: cout_in=1 with sum_in[15:0]=0xFFFF, 16 samples, default parameters -> overflow=1; acc_out=0xFFFFF with the macro, 0xFFFF0 without it.
REQ-035 Scenario 3: out_ready=0 in DONE, 6 pushes attempted -> 4 accepted, in_ready=0 afterwards, acc_out unchanged; out_ready=1 -> FIFO drains into the next burst.
REQ-036 Scenario 4: acc_clear pulse after 7 of 16 samples -> acc_count=0 and no out_valid; the next 16 samples produce the correct total.
REQ-037 Scenario 5: rst=0 for one cycle while in DONE with 3 samples buffered -> all outputs at reset values; the next burst is unaffected.
REQ-038 Scenario 6: acc_clear and an out_valid/out_ready handshake in the same cycle -> total dropped, FSM in ACCUM, acc_count=0.
